// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding, load-use bubbling, EX backpressure and flush.
// Define ID_FWD_EN to build the EX/MEM forwarding muxes; otherwise RAW hazards stall until writeback.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  id_src1,
  input  logic [XLEN-1:0]  id_src2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_we,
  input  logic             id_is_load,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [OP_W-1:0]  id_op,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             ex_ready,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_we,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             flush,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_src1,
  output logic [XLEN-1:0]  ex_src2,
  output logic [REG_W-1:0] ex_rd,
  output logic             ex_reg_we,
  output logic             ex_is_load,
  output logic [XLEN-1:0]  ex_imm,
  output logic [OP_W-1:0]  ex_op
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [REG_W-1:0] rd;
    logic             reg_we;
    logic             is_load;
    logic [XLEN-1:0]  imm;
    logic [OP_W-1:0]  op;
  } ex_entry_t;

  ex_entry_t        ex_q, ex_d;
  logic             load_use;
  logic             hazard;
  logic [XLEN-1:0]  opnd1, opnd2;

  always_comb begin
    load_use = ex_q.valid & ex_q.is_load & ex_q.reg_we & (ex_q.rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
  end

`ifdef ID_FWD_EN
  // Loads in EX have no data yet, so they are excluded from the EX forwarding path.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic             use_rs,
    input logic [REG_W-1:0] rs,
    input logic [XLEN-1:0]  rf_data,
    input logic             ex_hit_ok,
    input logic [REG_W-1:0] ex_dst,
    input logic [XLEN-1:0]  ex_data,
    input logic             mem_hit_ok,
    input logic [REG_W-1:0] mem_dst,
    input logic [XLEN-1:0]  mem_data
  );
    if (!use_rs)                      return rf_data;
    if (rs == '0)                     return '0;
    if (ex_hit_ok && ex_dst == rs)    return ex_data;
    if (mem_hit_ok && mem_dst == rs)  return mem_data;
    return rf_data;
  endfunction

  logic ex_fwd_ok, mem_fwd_ok;

  always_comb begin
    ex_fwd_ok  = ex_q.valid & ex_q.reg_we & ~ex_q.is_load;
    mem_fwd_ok = mem_valid & mem_reg_we;
    opnd1  = fwd_operand(id_use_rs1, id_rs1, id_src1, ex_fwd_ok, ex_q.rd, ex_result,
                         mem_fwd_ok, mem_rd, mem_result);
    opnd2  = fwd_operand(id_use_rs2, id_rs2, id_src2, ex_fwd_ok, ex_q.rd, ex_result,
                         mem_fwd_ok, mem_rd, mem_result);
    hazard = load_use;
  end
`else
  logic raw1, raw2;
  logic unused_fwd_data;

  // Without forwarding, any in-flight writer of a used source blocks ID until it retires.
  always_comb begin
    raw1 = id_use_rs1 & (id_rs1 != '0) &
           ((ex_q.valid & ex_q.reg_we & (ex_q.rd == id_rs1)) |
            (mem_valid & mem_reg_we & (mem_rd == id_rs1)));
    raw2 = id_use_rs2 & (id_rs2 != '0) &
           ((ex_q.valid & ex_q.reg_we & (ex_q.rd == id_rs2)) |
            (mem_valid & mem_reg_we & (mem_rd == id_rs2)));
    opnd1  = id_src1;
    opnd2  = id_src2;
    hazard = load_use | raw1 | raw2;
  end

  assign unused_fwd_data = ^{ex_result, mem_result};
`endif

  assign stall_id = ~rst & id_valid & (hazard | ~ex_ready) & ~flush;

  // NOTE: ex_d starts as a copy of ex_q so every path assigns it and no latch is inferred.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid  = 1'b0;
      ex_d.reg_we = 1'b0;
    end else if (ex_ready) begin
      if (hazard) begin
        ex_d.valid  = 1'b0;
        ex_d.reg_we = 1'b0;
      end else begin
        ex_d.valid   = id_valid;
        ex_d.src1    = opnd1;
        ex_d.src2    = opnd2;
        ex_d.rd      = id_rd;
        ex_d.reg_we  = id_valid & id_reg_we;
        ex_d.is_load = id_is_load;
        ex_d.imm     = id_imm;
        ex_d.op      = id_op;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid   = ex_q.valid;
  assign ex_src1    = ex_q.src1;
  assign ex_src2    = ex_q.src2;
  assign ex_rd      = ex_q.rd;
  assign ex_reg_we  = ex_q.reg_we;
  assign ex_is_load = ex_q.is_load;
  assign ex_imm     = ex_q.imm;
  assign ex_op      = ex_q.op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by random traffic,
// all compared against a behavioural model of the EX entry kept in the bench.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int OP_W  = 6;

`ifdef ID_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk, rst;
  logic             id_valid, id_use_rs1, id_use_rs2, id_reg_we, id_is_load;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd, mem_rd;
  logic [XLEN-1:0]  id_src1, id_src2, id_imm, ex_result, mem_result;
  logic [OP_W-1:0]  id_op;
  logic             ex_ready, mem_valid, mem_reg_we, flush;
  logic             stall_id, ex_valid, ex_reg_we, ex_is_load;
  logic [XLEN-1:0]  ex_src1, ex_src2, ex_imm;
  logic [REG_W-1:0] ex_rd;
  logic [OP_W-1:0]  ex_op;

  id_ex_stage #(.XLEN(XLEN), .REG_W(REG_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_src1(id_src1), .id_src2(id_src2),
    .id_rd(id_rd), .id_reg_we(id_reg_we), .id_is_load(id_is_load), .id_imm(id_imm),
    .id_op(id_op), .ex_result(ex_result), .ex_ready(ex_ready), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .ex_imm(ex_imm),
    .ex_op(ex_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction currently held in EX.
  typedef struct {
    logic             valid;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
    logic [XLEN-1:0]  imm;
    logic [OP_W-1:0]  op;
  } model_t;

  model_t m;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ex_writes(input logic [REG_W-1:0] r);
    return m.valid && m.we && m.rd == r;
  endfunction

  function automatic bit mem_writes(input logic [REG_W-1:0] r);
    return mem_valid && mem_reg_we && mem_rd == r;
  endfunction

  // Does reading register r now require a bubble?
  function automatic bit src_blocked(input logic use_r, input logic [REG_W-1:0] r);
    if (!use_r || r == 0) return 1'b0;
    if (ex_writes(r) && m.load) return 1'b1;
    if (!FWD && (ex_writes(r) || mem_writes(r))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit needs_bubble();
    return src_blocked(id_use_rs1, id_rs1) || src_blocked(id_use_rs2, id_rs2);
  endfunction

  // Value the instruction should see for source r: newest in-flight producer wins.
  function automatic logic [XLEN-1:0] operand(input logic use_r, input logic [REG_W-1:0] r,
                                              input logic [XLEN-1:0] rf);
    if (!FWD || !use_r) return rf;
    if (r == 0) return '0;
    if (ex_writes(r) && !m.load) return ex_result;
    if (mem_writes(r)) return mem_result;
    return rf;
  endfunction

  function automatic bit model_stall();
    return !rst && id_valid && !flush && (needs_bubble() || !ex_ready);
  endfunction

  function automatic model_t model_next();
    model_t n = m;
    if (rst) begin
      n = '{valid: 1'b0, src1: '0, src2: '0, rd: '0, we: 1'b0, load: 1'b0, imm: '0, op: '0};
    end else if (flush) begin
      n.valid = 1'b0;
      n.we    = 1'b0;
    end else if (!ex_ready) begin
      n = m;
    end else if (needs_bubble()) begin
      n.valid = 1'b0;
      n.we    = 1'b0;
    end else begin
      n.valid = id_valid;
      n.src1  = operand(id_use_rs1, id_rs1, id_src1);
      n.src2  = operand(id_use_rs2, id_rs2, id_src2);
      n.rd    = id_rd;
      n.we    = id_valid && id_reg_we;
      n.load  = id_is_load;
      n.imm   = id_imm;
      n.op    = id_op;
    end
    return n;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".ex_valid"},   64'(ex_valid),   64'(m.valid));
    check({tag, ".ex_src1"},    64'(ex_src1),    64'(m.src1));
    check({tag, ".ex_src2"},    64'(ex_src2),    64'(m.src2));
    check({tag, ".ex_rd"},      64'(ex_rd),      64'(m.rd));
    check({tag, ".ex_reg_we"},  64'(ex_reg_we),  64'(m.we));
    check({tag, ".ex_is_load"}, 64'(ex_is_load), 64'(m.load));
    check({tag, ".ex_imm"},     64'(ex_imm),     64'(m.imm));
    check({tag, ".ex_op"},      64'(ex_op),      64'(m.op));
  endtask

  // Inputs are stable here (set 1 ns after the previous edge); check stall, clock, check state.
  task automatic cycle(input string tag);
    model_t n;
    #2;
    check({tag, ".stall_id"}, 64'(stall_id), 64'(model_stall()));
    n = model_next();
    @(posedge clk);
    m = n;
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; id_src1 = '0; id_src2 = '0; id_rd = '0; id_reg_we = 1'b0;
    id_is_load = 1'b0; id_imm = '0; id_op = '0; ex_result = '0; ex_ready = 1'b1;
    mem_valid = 1'b0; mem_rd = '0; mem_reg_we = 1'b0; mem_result = '0; flush = 1'b0;
  endtask

  task automatic issue_writer(input logic [REG_W-1:0] rd, input logic is_load, input string tag);
    idle_inputs();
    id_valid = 1'b1; id_rd = rd; id_reg_we = 1'b1; id_is_load = is_load;
    id_imm = 32'h100 + 32'(rd); id_op = 6'h2A;
    cycle(tag);
  endtask

  task automatic random_inputs();
    rst        = ($urandom_range(0, 63) == 0);
    id_valid   = ($urandom_range(0, 7) != 0);
    id_rs1     = REG_W'($urandom_range(0, 3));
    id_rs2     = REG_W'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom_range(0, 1));
    id_use_rs2 = 1'($urandom_range(0, 1));
    id_src1    = $urandom;
    id_src2    = $urandom;
    id_rd      = REG_W'($urandom_range(0, 3));
    id_reg_we  = ($urandom_range(0, 3) != 0);
    id_is_load = ($urandom_range(0, 2) == 0);
    id_imm     = $urandom;
    id_op      = OP_W'($urandom_range(0, 63));
    ex_result  = $urandom;
    ex_ready   = ($urandom_range(0, 3) != 0);
    mem_valid  = 1'($urandom_range(0, 1));
    mem_rd     = REG_W'($urandom_range(0, 3));
    mem_reg_we = 1'($urandom_range(0, 1));
    mem_result = $urandom;
    flush      = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    m = '{valid: 1'b0, src1: '0, src2: '0, rd: '0, we: 1'b0, load: 1'b0, imm: '0, op: '0};

    // Reset with every input driven active.
    idle_inputs();
    rst = 1'b1; id_valid = 1'b1; id_rs1 = '1; id_rs2 = '1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_src1 = '1; id_src2 = '1; id_rd = '1; id_reg_we = 1'b1; id_is_load = 1'b1; id_imm = '1;
    id_op = '1; ex_result = '1; ex_ready = 1'b0; mem_valid = 1'b1; mem_rd = '1;
    mem_reg_we = 1'b1; mem_result = '1; flush = 1'b0;
    #1;
    cycle("reset0");
    cycle("reset1");

    // ALU result in EX forwarded to a dependent instruction.
    issue_writer(5'd5, 1'b0, "add_x5");
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_src1 = 32'hAA; ex_result = 32'h11;
    id_rd = 5'd6; id_reg_we = 1'b1;
    cycle("ex_fwd");
    cycle("ex_fwd_drain");

    // Load-use: one bubble, then the load's data arrives from MEM.
    issue_writer(5'd7, 1'b1, "lw_x7");
    idle_inputs();
    id_valid = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_src2 = 32'h55; id_rd = 5'd8;
    id_reg_we = 1'b1;
    cycle("load_use_bubble");
    mem_valid = 1'b1; mem_rd = 5'd7; mem_reg_we = 1'b1; mem_result = 32'h1234;
    cycle("load_use_mem_fwd");

    // EX and MEM both write x3: EX is newer and wins.
    issue_writer(5'd3, 1'b0, "add_x3");
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_src1 = 32'h99; ex_result = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_reg_we = 1'b1; mem_result = 32'h2;
    cycle("ex_over_mem");

    // x0 is never forwarded and never stalls.
    issue_writer(5'd0, 1'b0, "write_x0");
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_src1 = 32'h77; ex_result = 32'hFF;
    cycle("x0_read");

    // Backpressure for three cycles with a flush in the middle.
    issue_writer(5'd9, 1'b0, "bp_setup");
    idle_inputs();
    id_valid = 1'b1; id_rd = 5'd10; id_reg_we = 1'b1; id_imm = 32'hBEEF; ex_ready = 1'b0;
    cycle("bp_hold1");
    flush = 1'b1;
    cycle("bp_flush");
    flush = 1'b0;
    cycle("bp_hold3");
    ex_ready = 1'b1;
    cycle("bp_release");

    // Reset while a load-use stall is pending.
    issue_writer(5'd4, 1'b1, "lw_x4");
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd4; id_use_rs1 = 1'b1; id_src1 = 32'h44;
    cycle("stall_pending");
    rst = 1'b1;
    cycle("rst_mid_stall");
    rst = 1'b0;
    cycle("after_rst");

    for (int i = 0; i < 600; i++) begin
      random_inputs();
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
